bcd_down_timer: RTL and testbench



---
 rtl/bcd_down_timer_if.sv | 24 ++
 rtl/bcd_down_timer.sv | 118 +++++++++++
 tb/tb_bcd_down_timer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD down-timer.
// The driver side issues load/start/pause; the timer returns count and status.
interface bcd_down_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic                  auto_reload;
    logic [4*DIGITS-1:0]   q;
    logic                  running;
    logic                  done;

    modport master (
        output load, load_val, start, pause, auto_reload,
        input  q, running, done
    );

    modport slave (
        input  load, load_val, start, pause, auto_reload,
        output q, running, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with IDLE/RUN/DONE control,
// terminal-count pulse and optional auto-reload.
module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input  logic              clock,
    input  logic              clear,
    bcd_down_timer_if.slave   bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   count, count_nxt;
    logic [W-1:0]   reload, reload_nxt;
    logic           done_r, done_nxt;
    logic           running_r;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Borrow ripples upward only through digits that are 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        if (bus.load) begin
            count_nxt  = clamp(bus.load_val);
            reload_nxt = clamp(bus.load_val);
            state_nxt  = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && count != '0) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        if (count == ONE) begin
                            done_nxt = 1'b1;
                            if (bus.auto_reload && reload != '0) begin
                                count_nxt = reload;
                            end else begin
                                count_nxt = '0;
                                state_nxt = DONE;
                            end
                        end else if (count != '0) begin
                            count_nxt = bcd_dec(count);
                        end
                    end
                end
                DONE: begin
                    if (bus.start && reload != '0) begin
                        count_nxt = reload;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            count     <= '0;
            reload    <= '0;
            done_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            reload    <= reload_nxt;
            done_r    <= done_nxt;
            running_r <= (state_nxt == RUN);
        end
    end

    assign bus.q       = count;
    assign bus.running = running_r;
    assign bus.done    = done_r;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed table and sequence checks for bcd_down_timer.
module tb_bcd_down_timer;
    logic clock;
    logic clear;
    int   checks;
    int   errors;

    bcd_down_timer_if #(.DIGITS(2)) bus ();

    bcd_down_timer #(.DIGITS(2)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       ld;
        logic [7:0] val;
        logic       st;
        logic       pa;
        logic       ar;
        logic [7:0] q;
        logic       run;
        logic       dn;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(logic ld, logic [7:0] val, logic st,
                                logic pa, logic ar, logic [7:0] q,
                                logic run, logic dn);
        vec_t v;
        v = '{ld, val, st, pa, ar, q, run, dn};
        return v;
    endfunction

    function automatic logic [7:0] bcd(int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(string name, logic [7:0] q, logic run, logic dn);
        chk({name, "_q"}, bus.q, q);
        chk({name, "_run"}, {7'd0, bus.running}, {7'd0, run});
        chk({name, "_done"}, {7'd0, bus.done}, {7'd0, dn});
    endtask

    initial begin
        int pulses;
        logic [7:0] eq;
        checks = 0;
        errors = 0;
        tbl[0]  = mk(1, 8'hA7, 0, 0, 0, 8'h97, 0, 0);
        tbl[1]  = mk(1, 8'hFF, 0, 0, 0, 8'h99, 0, 0);
        tbl[2]  = mk(1, 8'h3C, 0, 0, 0, 8'h39, 0, 0);
        tbl[3]  = mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tbl[4]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tbl[6]  = mk(1, 8'h05, 0, 0, 0, 8'h05, 0, 0);
        tbl[7]  = mk(0, 8'h00, 1, 0, 0, 8'h05, 1, 0);
        tbl[8]  = mk(0, 8'h00, 0, 0, 0, 8'h04, 1, 0);
        tbl[9]  = mk(0, 8'h00, 0, 0, 0, 8'h03, 1, 0);
        tbl[10] = mk(0, 8'h00, 0, 1, 0, 8'h03, 1, 0);
        tbl[11] = mk(0, 8'h00, 0, 1, 0, 8'h03, 1, 0);
        tbl[12] = mk(0, 8'h00, 0, 1, 0, 8'h03, 1, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 0, 8'h02, 1, 0);
        tbl[14] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 0);
        tbl[15] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        tbl[16] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tbl[17] = mk(0, 8'h00, 1, 0, 0, 8'h05, 1, 0);
        tbl[18] = mk(0, 8'h00, 1, 0, 0, 8'h04, 1, 0);
        tbl[19] = mk(0, 8'h00, 1, 1, 0, 8'h04, 1, 0);
        tbl[20] = mk(0, 8'h00, 0, 0, 0, 8'h03, 1, 0);
        tbl[21] = mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tbl[22] = mk(1, 8'h02, 0, 0, 0, 8'h02, 0, 0);
        tbl[23] = mk(0, 8'h00, 1, 1, 0, 8'h02, 1, 0);
        tbl[24] = mk(0, 8'h00, 0, 1, 0, 8'h02, 1, 0);
        tbl[25] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 0);
        tbl[26] = mk(0, 8'h00, 0, 0, 1, 8'h02, 1, 1);
        tbl[27] = mk(0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
        tbl[28] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        tbl[29] = mk(0, 8'h00, 1, 0, 0, 8'h02, 1, 0);
        tbl[30] = mk(1, 8'h9A, 0, 0, 0, 8'h99, 0, 0);

        clear           = 1'b1;
        bus.load        = 1'b0;
        bus.load_val    = 8'h00;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.auto_reload = 1'b0;
        #3;
        chk_all("reset", 8'h00, 1'b0, 1'b0);
        step();
        clear = 1'b0;
        step();
        chk_all("post_reset", 8'h00, 1'b0, 1'b0);

        // Load 25, count down to terminal count
        bus.load = 1'b1;
        bus.load_val = 8'h25;
        step();
        bus.load = 1'b0;
        chk_all("ld25", 8'h25, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_all("start25", 8'h25, 1'b1, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            step();
            chk_all($sformatf("cnt25_%0d", k), bcd(25 - k),
                    k < 25, k == 25);
        end
        step();
        chk_all("done25", 8'h00, 1'b0, 1'b0);

        // Auto-reload period of 10
        bus.load = 1'b1;
        bus.load_val = 8'h10;
        bus.auto_reload = 1'b1;
        step();
        bus.load = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_all("ar_start", 8'h10, 1'b1, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            eq = (k % 10 == 0) ? 8'h10 : bcd(10 - (k % 10));
            if (bus.done) pulses++;
            chk_all($sformatf("ar_%0d", k), eq, 1'b1, k % 10 == 0);
        end
        chk("ar_pulses", 8'(pulses), 8'd3);
        bus.auto_reload = 1'b0;

        foreach (tbl[i]) begin
            bus.load        = tbl[i].ld;
            bus.load_val    = tbl[i].val;
            bus.start       = tbl[i].st;
            bus.pause       = tbl[i].pa;
            bus.auto_reload = tbl[i].ar;
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].q, tbl[i].run, tbl[i].dn);
        end
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.auto_reload = 1'b0;

        // Load aborts a run, then clear between edges
        bus.load = 1'b1;
        bus.load_val = 8'h15;
        step();
        bus.load = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        chk_all("at12", 8'h12, 1'b1, 1'b0);
        bus.load = 1'b1;
        bus.load_val = 8'h40;
        step();
        bus.load = 1'b0;
        chk_all("abort40", 8'h40, 1'b0, 1'b0);
        step();
        chk_all("idle40", 8'h40, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        chk_all("at37", 8'h37, 1'b1, 1'b0);
        #3;
        clear = 1'b1;
        #1;
        chk_all("async_clr", 8'h00, 1'b0, 1'b0);
        step();
        clear = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_all("clr_start", 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
